// File: rtl/md_unit.sv
// Multiply/divide unit holding architectural HI/LO with fixed-latency commit.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops (codes 9-12).
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  EX_MDOp,
  input  logic [31:0] EX_A,
  input  logic [31:0] EX_B,
  output logic        EX_MD_start,
  output logic        EX_MD_busy,
  output logic [31:0] EX_MD_RD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif
  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t      state_r, state_nx_s;
  logic [3:0]  cnt_r;
  logic [31:0] hi_r, lo_r, pend_hi_r, pend_lo_r;
  logic        pend_we_r;
  logic        is_start_s, start_s, commit_s, res_we_s;
  logic [63:0] res_s;
  logic [3:0]  cyc_s;

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] ax, bx;
    ax = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    bx = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    mul64 = ax * bx;
  endfunction

  // Divide on magnitudes, then fix signs: quotient toward zero, remainder follows dividend.
  function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] am, bm, q, r;
    logic        an, bn;
    an = sgn & a[31];
    bn = sgn & b[31];
    am = an ? (32'd0 - a) : a;
    bm = bn ? (32'd0 - b) : b;
    if (bm == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = am / bm;
      r = am % bm;
    end
    if (an ^ bn) q = 32'd0 - q;
    else         q = q;
    if (an) r = 32'd0 - r;
    else    r = r;
    div64 = {r, q};
  endfunction

  // Decode the op and compute the result that would be captured at acceptance.
  always_comb begin
    is_start_s = 1'b0;
    res_we_s   = 1'b0;
    res_s      = 64'd0;
    cyc_s      = 4'd0;
    case (EX_MDOp)
      OP_MULT:  begin is_start_s = 1'b1; res_we_s = 1'b1; res_s = mul64(EX_A, EX_B, 1'b1); cyc_s = MULT_LAT; end
      OP_MULTU: begin is_start_s = 1'b1; res_we_s = 1'b1; res_s = mul64(EX_A, EX_B, 1'b0); cyc_s = MULT_LAT; end
      OP_DIV:   begin is_start_s = 1'b1; res_we_s = (EX_B != 32'd0); res_s = div64(EX_A, EX_B, 1'b1); cyc_s = DIV_LAT; end
      OP_DIVU:  begin is_start_s = 1'b1; res_we_s = (EX_B != 32'd0); res_s = div64(EX_A, EX_B, 1'b0); cyc_s = DIV_LAT; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_start_s = 1'b1; res_we_s = 1'b1; res_s = {hi_r, lo_r} + mul64(EX_A, EX_B, 1'b1); cyc_s = MULT_LAT; end
      OP_MADDU: begin is_start_s = 1'b1; res_we_s = 1'b1; res_s = {hi_r, lo_r} + mul64(EX_A, EX_B, 1'b0); cyc_s = MULT_LAT; end
      OP_MSUB:  begin is_start_s = 1'b1; res_we_s = 1'b1; res_s = {hi_r, lo_r} - mul64(EX_A, EX_B, 1'b1); cyc_s = MULT_LAT; end
      OP_MSUBU: begin is_start_s = 1'b1; res_we_s = 1'b1; res_s = {hi_r, lo_r} - mul64(EX_A, EX_B, 1'b0); cyc_s = MULT_LAT; end
`endif
      default:  begin is_start_s = 1'b0; end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nx_s;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE: state_nx_s = start_s  ? ST_BUSY : ST_IDLE;
      ST_BUSY: state_nx_s = commit_s ? ST_IDLE : ST_BUSY;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs: acceptance and commit strobes.
  always_comb begin
    start_s  = 1'b0;
    commit_s = 1'b0;
    if (state_r == ST_IDLE) begin
      start_s = is_start_s;
    end else begin
      commit_s = (cnt_r == 4'd1);
    end
  end

  // Datapath: pending capture, countdown, commit and direct HI/LO moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_we_r <= 1'b0;
      cnt_r     <= 4'd0;
    end else if (start_s) begin
      pend_hi_r <= res_s[63:32];
      pend_lo_r <= res_s[31:0];
      pend_we_r <= res_we_s;
      cnt_r     <= cyc_s;
    end else if (state_r == ST_BUSY) begin
      cnt_r <= cnt_r - 4'd1;
      if (commit_s && pend_we_r) begin
        hi_r <= pend_hi_r;
        lo_r <= pend_lo_r;
      end
    end else if (EX_MDOp == OP_MTHI) begin
      hi_r <= EX_A;
    end else if (EX_MDOp == OP_MTLO) begin
      lo_r <= EX_A;
    end
  end

  // Read port returns committed registers only.
  always_comb begin
    EX_MD_RD = 32'd0;
    case (EX_MDOp)
      OP_MFHI: EX_MD_RD = hi_r;
      OP_MFLO: EX_MD_RD = lo_r;
      default: EX_MD_RD = 32'd0;
    endcase
  end

  assign EX_MD_start = start_s;
  assign EX_MD_busy  = (state_r == ST_BUSY);
  assign HI          = hi_r;
  assign LO          = lo_r;

endmodule
